ukwd_reflector: RTL and testbench



---
 rtl/ukwd_reflector_pkg.sv | 33 +++
 rtl/ukwd_reflector_if.sv | 12 +
 rtl/ukwd_reflector_pair_check.sv | 25 ++
 rtl/ukwd_reflector.sv | 105 ++++++++++
 tb/tb_ukwd_reflector.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ukwd_reflector_pkg.sv
// Shared types and constants for the ENIGMA551 UKW-D rewirable reflector.
package enigma_pkg;

    localparam int unsigned LW          = 5;
    localparam int unsigned NUM_LETTERS = 26;
    localparam int unsigned NUM_PAIRS   = 13;

    typedef logic [LW-1:0] letter_t;
    typedef logic [NUM_LETTERS-1:0][LW-1:0] table_t;
    typedef logic [1:0] err_t;

    localparam letter_t LAST_LETTER = letter_t'(NUM_LETTERS - 1);

    localparam err_t ERR_NONE   = 2'd0;
    localparam err_t ERR_SELF   = 2'd1;
    localparam err_t ERR_RANGE  = 2'd2;
    localparam err_t ERR_REUSED = 2'd3;

    // UKW-B wiring, entry 25 leftmost down to entry 0 rightmost
    localparam table_t UKW_B = {
        5'd19, 5'd0,  5'd9,  5'd21, 5'd22, 5'd2,  5'd25, 5'd5,  5'd1,
        5'd4,  5'd8,  5'd12, 5'd10, 5'd14, 5'd6,  5'd13, 5'd23, 5'd15,
        5'd3,  5'd11, 5'd18, 5'd16, 5'd7,  5'd20, 5'd17, 5'd24
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_ERROR
    } load_state_t;

endpackage

// File: rtl/ukwd_reflector_if.sv
// Pair-loading valid/ready channel into the UKW-D reflector.
interface ukwd_reflector_if;
    import enigma_pkg::*;

    logic    pair_valid;
    logic    pair_ready;
    letter_t pair_a;
    letter_t pair_b;

    modport master (output pair_valid, output pair_a, output pair_b, input pair_ready);
    modport slave  (input pair_valid, input pair_a, input pair_b, output pair_ready);
endinterface

// File: rtl/ukwd_reflector_pair_check.sv
// Combinational legality check of one letter pair against the used-letter bitmap.
module ukwd_pair_check
    import enigma_pkg::*;
(
    input  letter_t                pair_a,
    input  letter_t                pair_b,
    input  logic [NUM_LETTERS-1:0] used,
    output logic                   legal,
    output err_t                   err_code
);

    // Range is tested first so the bitmap is never indexed out of bounds
    always_comb begin
        err_code = ERR_NONE;
        if (pair_a > LAST_LETTER || pair_b > LAST_LETTER) begin
            err_code = ERR_RANGE;
        end else if (pair_a == pair_b) begin
            err_code = ERR_SELF;
        end else if (used[pair_a] || used[pair_b]) begin
            err_code = ERR_REUSED;
        end
        legal = (err_code == ERR_NONE);
    end

endmodule

// File: rtl/ukwd_reflector.sv
// UKW-D field-rewirable reflector: pair loader into a shadow table, atomic commit.
// Optional REFLECTOR_READBACK_EN adds a registered active-table readback port.
module ukwd_reflector
    import enigma_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_start,
    ukwd_reflector_if.slave pair_if,
    output logic   load_busy,
    output logic   load_done,
    output err_t   load_err,
    input  letter_t lookup_in,
    output letter_t lookup_out
`ifdef REFLECTOR_READBACK_EN
    ,
    input  letter_t rd_idx,
    output letter_t rd_data
`endif
);

    localparam logic [3:0] CNT_LAST = 4'(NUM_PAIRS - 1);
    localparam logic [3:0] CNT_FULL = 4'(NUM_PAIRS);

    load_state_t            state, state_nxt;
    table_t                 active, shadow;
    logic [NUM_LETTERS-1:0] used;
    logic [3:0]             pair_cnt;
    logic                   chk_legal;
    err_t                   chk_err;
    logic                   accept;
    logic                   restart;

    ukwd_pair_check u_check (
        .pair_a   (pair_if.pair_a),
        .pair_b   (pair_if.pair_b),
        .used     (used),
        .legal    (chk_legal),
        .err_code (chk_err)
    );

    // A restart in LOAD takes priority over a pair presented in the same cycle
    assign restart            = load_start && (state != ST_COMMIT);
    assign pair_if.pair_ready = (state == ST_LOAD) && !load_start;
    assign accept             = pair_if.pair_valid && pair_if.pair_ready;
    assign load_busy          = (state == ST_LOAD);
    assign load_done          = (state == ST_COMMIT);
    assign lookup_out         = (lookup_in <= LAST_LETTER) ? active[lookup_in] : lookup_in;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (load_start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (accept) begin
                    if (!chk_legal)                 state_nxt = ST_ERROR;
                    else if (pair_cnt == CNT_LAST)  state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            ST_ERROR:  if (load_start) state_nxt = ST_LOAD;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            active   <= UKW_B;
            shadow   <= '0;
            used     <= '0;
            pair_cnt <= '0;
            load_err <= ERR_NONE;
        end else begin
            state <= state_nxt;
            if (restart) begin
                used     <= '0;
                pair_cnt <= '0;
                load_err <= ERR_NONE;
            end else if (accept) begin
                if (chk_legal) begin
                    shadow[pair_if.pair_a] <= pair_if.pair_b;
                    shadow[pair_if.pair_b] <= pair_if.pair_a;
                    used[pair_if.pair_a]   <= 1'b1;
                    used[pair_if.pair_b]   <= 1'b1;
                    if (pair_cnt != CNT_FULL) pair_cnt <= pair_cnt + 4'd1;
                end else begin
                    load_err <= chk_err;
                end
            end
            if (state == ST_COMMIT) active <= shadow;
        end
    end

`ifdef REFLECTOR_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= (rd_idx <= LAST_LETTER) ? active[rd_idx] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_ukwd_reflector.sv
// Self-checking bench for ukwd_reflector: pair-list reference model plus directed and random loads.
module tb_ukwd_reflector;

    localparam int M_IDLE = 0, M_LOAD = 1, M_COMMIT = 2, M_ERROR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_start = 1'b0;
    logic       load_busy, load_done;
    logic [1:0] load_err;
    logic [4:0] lookup_in = 5'd0;
    logic [4:0] lookup_out;
`ifdef REFLECTOR_READBACK_EN
    logic [4:0] rd_idx = 5'd0;
    logic [4:0] rd_data;
`endif

    ukwd_reflector_if pif ();

    ukwd_reflector dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .pair_if    (pif.slave),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .lookup_in  (lookup_in),
        .lookup_out (lookup_out)
`ifdef REFLECTOR_READBACK_EN
        ,
        .rd_idx     (rd_idx),
        .rd_data    (rd_data)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: wiring as a list of accepted pairs, table rebuilt on commit
    int m_mode = M_IDLE;
    int m_active [26];
    int pa_q [$];
    int pb_q [$];
    int m_err = 0;
    int m_rd  = 0;
    int perm [26];

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ukwb();
        string s;
        int a, b;
        s = "AYBRCUDHEQFSGLIPJXKNMOTZVW";
        for (int i = 0; i < 13; i++) begin
            a = int'(s.getc(2 * i)) - 65;
            b = int'(s.getc(2 * i + 1)) - 65;
            m_active[a] = b;
            m_active[b] = a;
        end
    endtask

    function automatic bit letter_used(input int x);
        foreach (pa_q[i]) if (pa_q[i] == x || pb_q[i] == x) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int a, b, e;
`ifdef REFLECTOR_READBACK_EN
        m_rd = rst ? 0 : ((int'(rd_idx) < 26) ? m_active[rd_idx] : 0);
`endif
        if (rst) begin
            set_ukwb();
            m_mode = M_IDLE;
            pa_q.delete();
            pb_q.delete();
            m_err = 0;
        end else begin
            case (m_mode)
                M_COMMIT: begin
                    foreach (pa_q[i]) begin
                        m_active[pa_q[i]] = pb_q[i];
                        m_active[pb_q[i]] = pa_q[i];
                    end
                    m_mode = M_IDLE;
                end
                M_IDLE, M_ERROR: begin
                    if (load_start) begin
                        pa_q.delete(); pb_q.delete(); m_err = 0; m_mode = M_LOAD;
                    end
                end
                default: begin
                    if (load_start) begin
                        pa_q.delete(); pb_q.delete(); m_err = 0;
                    end else if (pif.pair_valid) begin
                        a = int'(pif.pair_a);
                        b = int'(pif.pair_b);
                        if (a >= 26 || b >= 26)                    e = 2;
                        else if (a == b)                           e = 1;
                        else if (letter_used(a) || letter_used(b)) e = 3;
                        else                                       e = 0;
                        if (e != 0) begin
                            m_err = e; m_mode = M_ERROR;
                        end else begin
                            pa_q.push_back(a); pb_q.push_back(b);
                            if (pa_q.size() == 13) m_mode = M_COMMIT;
                        end
                    end
                end
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("pair_ready", int'(pif.pair_ready), int'(m_mode == M_LOAD && !load_start));
            cmp("load_busy",  int'(load_busy),  int'(m_mode == M_LOAD));
            cmp("load_done",  int'(load_done),  int'(m_mode == M_COMMIT));
            cmp("load_err",   int'(load_err),   m_err);
            cmp("lookup_out", int'(lookup_out),
                (int'(lookup_in) < 26) ? m_active[lookup_in] : int'(lookup_in));
`ifdef REFLECTOR_READBACK_EN
            cmp("rd_data", int'(rd_data), m_rd);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        chk_en = 1'b1;
        #1;
    endtask

    task automatic pin_lookup(input int in, input int exp);
        lookup_in = 5'(in);
        #1;
        cmp("lit_lookup", int'(lookup_out), exp);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input int a, input int b);
        pif.pair_valid = 1'b1;
        pif.pair_a = 5'(a);
        pif.pair_b = 5'(b);
        tick();
        pif.pair_valid = 1'b0;
    endtask

    task automatic shuffle();
        int j, t;
        for (int i = 0; i < 26; i++) perm[i] = i;
        for (int i = 25; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
    endtask

    initial begin
        int k;
        pif.pair_valid = 1'b0;
        pif.pair_a = 5'd0;
        pif.pair_b = 5'd0;
        set_ukwb();

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        cmp("lit_rst_ready", int'(pif.pair_ready), 0);
        cmp("lit_rst_err", int'(load_err), 0);
        pin_lookup(0, 24);
        pin_lookup(24, 0);
        pin_lookup(30, 30);
        tick();

        // Full legal load (0,1)..(24,25) with a two-cycle valid gap
        start_load();
        for (int i = 0; i < 13; i++) begin
            send(2 * i, 2 * i + 1);
            if (i == 4) begin tick(); tick(); end
        end
        cmp("lit_done", int'(load_done), 1);
        pin_lookup(0, 24);
        tick();
        pin_lookup(0, 1);
        pin_lookup(25, 24);
        cmp("lit_done_drop", int'(load_done), 0);
`ifdef REFLECTOR_READBACK_EN
        rd_idx = 5'd3;
        tick();
        cmp("lit_rd3", int'(rd_data), 2);
        rd_idx = 5'd27;
        tick();
        cmp("lit_rd27", int'(rd_data), 0);
`endif

        // Self-pair error leaves UKW-B in place
        rst = 1'b1; tick(); rst = 1'b0;
        start_load();
        send(3, 4); send(6, 9); send(5, 5);
        cmp("lit_err_self", int'(load_err), 1);
        cmp("lit_err_ready", int'(pif.pair_ready), 0);
        pin_lookup(0, 24);

        // Reuse, then out-of-range; ERROR only left by load_start
        start_load();
        send(0, 1); send(1, 7);
        cmp("lit_err_reuse", int'(load_err), 3);
        start_load();
        send(0, 26);
        pif.pair_valid = 1'b1;
        repeat (3) tick();
        pif.pair_valid = 1'b0;
        cmp("lit_err_range", int'(load_err), 2);
        start_load();
        cmp("lit_err_clear", int'(load_err), 0);

        // Restart after 6 pairs needs a complete fresh set
        for (int i = 0; i < 6; i++) send(2 * i, 2 * i + 1);
        start_load();
        for (int i = 0; i < 12; i++) send(25 - 2 * i, 24 - 2 * i);
        cmp("lit_no_done", int'(load_done), 0);
        cmp("lit_still_busy", int'(load_busy), 1);
        send(1, 0);
        cmp("lit_done2", int'(load_done), 1);
        tick();
        pin_lookup(0, 1);

        // Reset mid-load restores UKW-B
        start_load();
        send(0, 2); send(4, 6); send(8, 10);
        rst = 1'b1; tick(); rst = 1'b0;
        cmp("lit_rst_mid_ready", int'(pif.pair_ready), 0);
        pin_lookup(0, 24);

        // Randomised traffic
        shuffle();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(299, 0) == 0);
            load_start = ($urandom_range(49, 0) == 0);
            if (load_start) shuffle();
            k = pa_q.size();
            pif.pair_valid = ($urandom_range(1, 0) == 1);
            if (k < 13) begin
                pif.pair_a = 5'(perm[2 * k]);
                pif.pair_b = 5'(perm[2 * k + 1]);
            end else begin
                pif.pair_a = 5'($urandom_range(25, 0));
                pif.pair_b = 5'($urandom_range(25, 0));
            end
            if ($urandom_range(39, 0) == 0) pif.pair_b = 5'($urandom_range(31, 0));
            lookup_in = 5'($urandom_range(31, 0));
`ifdef REFLECTOR_READBACK_EN
            rd_idx = 5'($urandom_range(31, 0));
`endif
            tick();
        end
        rst = 1'b0;
        load_start = 1'b0;
        pif.pair_valid = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
